// File: rtl/demux1_to4_reg.sv
// ---------------------------------------------------------------------------
// demux1_to4_reg
//
// Purpose:
//   Routes a single data bit X to one of four registered output channels
//   selected by S. Each channel is a one-entry buffer with a valid/ready
//   handshake. A full channel stalls new input only while its consumer is
//   not ready. A simultaneous drain and refill of the same channel keeps it
//   full, so each channel can sustain one bit per cycle.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   X          in   data bit to route
//   S[1:0]     in   destination select (0..3 -> ch0..ch3)
//   IN_VALID   in   X and S are valid this cycle
//   IN_READY   out  block accepts X this cycle (combinational)
//   Z0..Z3     out  registered channel data (holds its value after draining)
//   V0..V3     out  channel data valid
//   CNT0..CNT3 out  per-channel completed-transfer count, CNT_W bits each
//                   (present only when DEMUX_CNT_EN is defined)
//   R0..R3     in   channel consumer ready
//
// Configuration:
//   DEMUX_CNT_EN  when defined, adds a wrapping transfer counter per channel
//                 that increments on every output handshake of that channel.
//   CNT_W         counter width (used only with DEMUX_CNT_EN).
// ---------------------------------------------------------------------------
module demux1_to4_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             X,
  input  logic [1:0]       S,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             Z0,
  output logic             Z1,
  output logic             Z2,
  output logic             Z3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1,
  output logic [CNT_W-1:0] CNT2,
  output logic [CNT_W-1:0] CNT3,
`endif
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3
);

  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0] v_q, v_d;
  logic [NUM_CH-1:0] z_q, z_d;

  logic [NUM_CH-1:0] ready_vec;
  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] out_hs;
  logic [NUM_CH-1:0] in_hs_vec;
  logic              in_ready;
  logic              in_hs;

  // Gather the per-channel consumer ready inputs into one vector.
  assign ready_vec = {R3, R2, R1, R0};

  // One-hot decode of the destination select.
  always_comb begin
    sel_onehot = '0;
    sel_onehot[S] = 1'b1;
  end

  // The addressed channel can take a new bit if it is empty, or if it is
  // being drained this same cycle (which is what allows back-to-back flow).
  assign in_ready = !v_q[S] || ready_vec[S];
  assign in_hs    = IN_VALID && in_ready;

  // Per-channel input and output handshakes.
  assign in_hs_vec = sel_onehot & {NUM_CH{in_hs}};
  assign out_hs    = v_q & ready_vec;

  // Next-state for every channel buffer. An input handshake always wins:
  // it either fills an empty entry or replaces one that is draining now.
  // Otherwise a drain empties the entry but leaves the data bit in place.
  always_comb begin
    v_d = v_q;
    z_d = z_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_hs_vec[k]) begin
        v_d[k] = 1'b1;
        z_d[k] = X;
      end else if (out_hs[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  // Channel state registers; reset discards any buffered data and
  // overrides handshakes happening in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      z_q <= '0;
    end else begin
      v_q <= v_d;
      z_q <= z_d;
    end
  end

  assign IN_READY = in_ready;

  assign Z0 = z_q[0];
  assign Z1 = z_q[1];
  assign Z2 = z_q[2];
  assign Z3 = z_q[3];

  assign V0 = v_q[0];
  assign V1 = v_q[1];
  assign V2 = v_q[2];
  assign V3 = v_q[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Count completed output transfers; natural binary overflow provides the
  // wrap from all-ones back to zero.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (out_hs[k]) begin
        cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Counter registers, cleared together with the channel state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign CNT0 = cnt_q[0];
  assign CNT1 = cnt_q[1];
  assign CNT2 = cnt_q[2];
  assign CNT3 = cnt_q[3];
`else
  // Without counters the width parameter has no consumer; tie it off here
  // so the default build stays warning-free.
  logic [CNT_W-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_demux1_to4_reg.sv
// ---------------------------------------------------------------------------
// tb_demux1_to4_reg
//
// Self-checking bench for demux1_to4_reg. A behavioural model tracks each
// channel as a buffer of capacity one (an occupancy count plus the last bit
// written) and optionally a running transfer total. Directed scenarios come
// first, followed by a long randomized run with occasional resets.
// ---------------------------------------------------------------------------
module tb_demux1_to4_reg;

  localparam int CNT_W = 8;
  localparam int DEPTH = 1;
  localparam int NUM_RANDOM = 2000;

  logic clk;
  logic rst;
  logic X;
  logic [1:0] S;
  logic IN_VALID;
  logic IN_READY;
  logic Z0, Z1, Z2, Z3;
  logic V0, V1, V2, V3;
  logic R0, R1, R2, R3;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] CNT0, CNT1, CNT2, CNT3;
`endif

  int checkCount;
  int errorCount;

  // Behavioural model state.
  int fillLevel [4];
  bit lastBit [4];
  int transfers [4];

  demux1_to4_reg #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .X        (X),
    .S        (S),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .Z0       (Z0),
    .Z1       (Z1),
    .Z2       (Z2),
    .Z3       (Z3),
    .V0       (V0),
    .V1       (V1),
    .V2       (V2),
    .V3       (V3),
`ifdef DEMUX_CNT_EN
    .CNT0     (CNT0),
    .CNT1     (CNT1),
    .CNT2     (CNT2),
    .CNT3     (CNT3),
`endif
    .R0       (R0),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the model's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational ready, advance the
  // model across the clock edge, then check every registered output.
  task automatic applyStimulus(input logic rstIn, input logic [1:0] selIn, input logic bitIn,
                               input logic validIn, input logic [3:0] readyIn);
    logic expReady;
    logic [3:0] vObs;
    logic [3:0] zObs;
    int selIdx;
    selIdx = int'(selIn);

    @(negedge clk);
    rst = rstIn;
    S = selIn;
    X = bitIn;
    IN_VALID = validIn;
    {R3, R2, R1, R0} = readyIn;
    #1;

    expReady = (fillLevel[selIdx] < DEPTH) || readyIn[selIdx];
    checkOutput("IN_READY", {31'd0, IN_READY}, {31'd0, expReady});

    if (rstIn) begin
      for (int k = 0; k < 4; k++) begin
        fillLevel[k] = 0;
        lastBit[k] = 1'b0;
        transfers[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fillLevel[k] > 0 && readyIn[k]) begin
          fillLevel[k] = fillLevel[k] - 1;
          transfers[k] = transfers[k] + 1;
        end
      end
      if (validIn && expReady) begin
        fillLevel[selIdx] = fillLevel[selIdx] + 1;
        lastBit[selIdx] = bitIn;
      end
    end

    @(posedge clk);
    #1;
    vObs = {V3, V2, V1, V0};
    zObs = {Z3, Z2, Z1, Z0};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("V%0d", k), {31'd0, vObs[k]}, (fillLevel[k] > 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("Z%0d", k), {31'd0, zObs[k]}, {31'd0, lastBit[k]});
    end
`ifdef DEMUX_CNT_EN
    checkOutput("CNT0", {{(32-CNT_W){1'b0}}, CNT0}, transfers[0] % (1 << CNT_W));
    checkOutput("CNT1", {{(32-CNT_W){1'b0}}, CNT1}, transfers[1] % (1 << CNT_W));
    checkOutput("CNT2", {{(32-CNT_W){1'b0}}, CNT2}, transfers[2] % (1 << CNT_W));
    checkOutput("CNT3", {{(32-CNT_W){1'b0}}, CNT3}, transfers[3] % (1 << CNT_W));
`endif
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int k = 0; k < 4; k++) begin
      fillLevel[k] = 0;
      lastBit[k] = 1'b0;
      transfers[k] = 0;
    end
    rst = 1'b1;
    X = 1'b0;
    S = 2'b00;
    IN_VALID = 1'b0;
    {R3, R2, R1, R0} = 4'b0000;

    // Two reset cycles; the first clears the unknown power-up state, so the
    // ready check is only meaningful from the second one onward.
    @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);

    // Single route to ch2, held until its consumer becomes ready.
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);

    // Stall on full ch1, then release with a simultaneous refill.
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b1111);

    // Streaming into ch3 with its consumer always ready.
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 4'b1000);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 4'b1000);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 4'b1000);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 4'b1000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b1000);

    // Independence: full, stalled ch0 does not block traffic to ch1.
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);

    // Reset while channels hold data and handshakes are offered.
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 4'b1111);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < NUM_RANDOM; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/demux1_to4_reg.md
DEMUX1_TO4_REG -- requirements
Module: demux1_to4_reg

Interface
REQ-001 Parameter CNT_W, default 8, width of each per-channel transfer counter; used only when DEMUX_CNT_EN is defined.
REQ-002 Single clock domain; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 X  input  1  data bit to route.
REQ-006 S  input  2  destination select: 2'b00 to ch0, 2'b01 to ch1, 2'b10 to ch2, 2'b11 to ch3.
REQ-007 IN_VALID  input  1  X and S valid this cycle.
REQ-008 IN_READY  output  1  block accepts X this cycle.
REQ-009 Z0..Z3  output  1 each  registered channel data.
REQ-010 V0..V3  output  1 each  channel data valid.
REQ-011 R0..R3  input  1 each  channel consumer ready.
REQ-012 CNT0..CNT3  output  CNT_W each  per-channel completed-transfer count; present only with DEMUX_CNT_EN.

Function
REQ-013 Each channel k SHALL be a one-entry buffer with two states: EMPTY (Vk=0) and FULL (Vk=1).
REQ-014 Input handshake SHALL occur when IN_VALID=1 and IN_READY=1 in the same cycle.
REQ-015 IN_READY SHALL be combinational: !V[S] || R[S], evaluated for the channel currently addressed by S.
REQ-016 On an input handshake, Z[S] SHALL load X and V[S] SHALL be 1 on the next clock edge: latency 1 cycle.
REQ-017 Output handshake on channel k SHALL occur when Vk=1 and Rk=1.
REQ-018 FULL to EMPTY SHALL occur on an output handshake with no same-cycle input handshake to k.
REQ-019 EMPTY to FULL SHALL occur on an input handshake to k.
REQ-020 Simultaneous output and input handshake on channel k SHALL keep Vk=1 and load the new X into Zk, giving back-to-back throughput of 1 bit per cycle per channel.
REQ-021 While Vk=1 and Rk=0, Zk SHALL hold stable and an input addressed to k SHALL be stalled (IN_READY=0).
REQ-022 Channels not addressed by S SHALL be unaffected by input activity; their drains proceed independently.
REQ-023 When IN_VALID=0, X and S SHALL be ignored and no channel state SHALL change except by drain.
REQ-024 Zk SHALL retain its last value after draining; only Vk qualifies the data.
REQ-025 Rk asserted while Vk=0 SHALL have no effect.

Reset
REQ-026 With rst=1 at a clock edge: V0..V3=0, Z0..Z3=0, CNT0..CNT3=0.
REQ-027 Reset SHALL override any same-cycle handshake; buffered data is discarded.
REQ-028 During rst=1, IN_READY SHALL follow REQ-015 from the reset state (evaluates to 1 after the first reset edge).

Configuration
REQ-029 Macro DEMUX_CNT_EN: when defined, CNTk SHALL increment by 1 on every output handshake of channel k and wrap from 2^CNT_W-1 to 0.
REQ-030 Without DEMUX_CNT_EN, CNT0..CNT3 ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset then idle: rst=1 for 2 cycles -> V0..V3=0, Z0..Z3=0, IN_READY=1, CNTk=0.
REQ-032 Single route: S=2'b10, X=1, IN_VALID=1 for 1 cycle, R2=0 -> next cycle V2=1, Z2=1, V0/V1/V3=0; remains held until R2=1, then V2=0 one cycle later.
REQ-033 Stall: ch1 FULL, R1=0, S=2'b01, IN_VALID=1 -> IN_READY=0, Z1 unchanged; raise R1 -> IN_READY=1, Z1 takes new X next cycle, V1 stays 1.
REQ-034 Streaming: R3=1 held, S=2'b11, X=1,0,1,1 on 4 consecutive cycles -> Z3=1,0,1,1 one cycle later each, V3=1 continuously, IN_READY=1 throughout.
REQ-035 Independence: ch0 FULL with R0=0 while S=2'b01 sends X=1 -> accepted, V1=1 next cycle, ch0 unchanged.
REQ-036 Counter wrap (DEMUX_CNT_EN, CNT_W=2): 5 output handshakes on ch0 -> CNT0 sequence 1,2,3,0,1; reset mid-stream -> CNT0=0, V0=0 next cycle.
